// File: rtl/fpu_ss_wb_ctrl.sv
// FPU subsystem writeback controller.
// Gates instruction issue to the FPU, tracks in-flight operations, routes FP
// results to the FP register file and buffers integer results in a small FIFO
// towards the CPU. CSR instructions wait until the subsystem is fully idle.
module fpu_ss_wb_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int RESP_DEPTH      = 2,
  parameter int ID_WIDTH        = 4,
  parameter int XLEN            = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 pop_valid_i,
  output logic                                 pop_ready_o,
  input  logic                                 use_fpu_i,
  input  logic                                 csr_instr_i,
  output logic                                 fpu_in_valid_o,
  input  logic                                 fpu_in_ready_i,
  input  logic                                 fpu_out_valid_i,
  output logic                                 fpu_out_ready_o,
  input  logic                                 fpu_out_rd_is_fp_i,
  input  logic [ID_WIDTH-1:0]                  fpu_out_id_i,
  input  logic [XLEN-1:0]                      fpu_out_data_i,
  output logic                                 fpr_we_o,
  output logic                                 c_p_valid_o,
  input  logic                                 c_p_ready_i,
  output logic [ID_WIDTH-1:0]                  c_p_id_o,
  output logic [XLEN-1:0]                      c_p_data_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic [$clog2(RESP_DEPTH+1)-1:0]      resp_usage_o,
  output logic                                 idle_o
);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int UW = $clog2(RESP_DEPTH+1);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);
  localparam logic [UW-1:0] FULL_CNT = UW'(RESP_DEPTH);

  typedef enum logic {RUN, DRAIN} state_e;
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [XLEN-1:0]     data;
  } resp_t;

  state_e          state;
  logic [OW-1:0]   outstanding;
  logic [UW-1:0]   usage;
  logic [PW-1:0]   wptr, rptr;
  resp_t           mem [RESP_DEPTH];

  logic in_run, issue, res_hs, enq, deq, fifo_full, csr_pop;

  assign outstanding_o = outstanding;
  assign resp_usage_o  = usage;
  assign idle_o        = (outstanding == '0) && (usage == '0);
  assign in_run        = (state == RUN);
  assign fifo_full     = (usage == FULL_CNT);
  assign csr_pop       = pop_valid_i & csr_instr_i;

  // Issue only while running and below the in-flight limit.
  assign fpu_in_valid_o = pop_valid_i & use_fpu_i & in_run & (outstanding < MAX_CNT);
  assign issue          = fpu_in_valid_o & fpu_in_ready_i;

  // Non-FPU, non-CSR pops retire immediately; CSR pops only once idle.
  assign pop_ready_o = issue
                     | (in_run & pop_valid_i & ~use_fpu_i & ~csr_instr_i)
                     | (in_run & csr_pop & idle_o);

  // Response FIFO head; a same-cycle dequeue frees a slot for the incoming result.
  assign c_p_valid_o     = (usage != '0);
  assign c_p_id_o        = mem[rptr].id;
  assign c_p_data_o      = mem[rptr].data;
  assign deq             = c_p_valid_o & c_p_ready_i;
  assign fpu_out_ready_o = fpu_out_rd_is_fp_i | ~fifo_full | deq;
  assign res_hs          = fpu_out_valid_i & fpu_out_ready_o;
  assign enq             = res_hs & ~fpu_out_rd_is_fp_i & (~fifo_full | deq);
  assign fpr_we_o        = fpu_out_valid_i & fpu_out_rd_is_fp_i;

  // RUN/DRAIN: a CSR that arrives while busy holds the pipe until idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (csr_pop && !idle_o) state <= DRAIN;
        DRAIN:   if (idle_o) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // In-flight counter; decrement saturates at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else begin
      case ({issue, res_hs})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      usage <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      case ({enq, deq})
        2'b10:   usage <= usage + 1'b1;
        2'b01:   usage <= usage - 1'b1;
        default: usage <= usage;
      endcase
    end
  end

  // FIFO storage is left unreset; contents are only observed while valid.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr] <= '{id: fpu_out_id_i, data: fpu_out_data_i};
  end

`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(res_hs && outstanding == '0))
    else $error("result handshake with no operation in flight");
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fpu_out_valid_i && !fpu_out_rd_is_fp_i && fifo_full && !deq && res_hs))
    else $error("enqueue into full response fifo");
`endif

endmodule

// File: tb/tb_fpu_ss_wb_ctrl.sv
// Bench for fpu_ss_wb_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based transaction model.
module tb_fpu_ss_wb_ctrl;
  localparam int MAXO = 4;
  localparam int DEP  = 2;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic pv, uf, csr, ir, ov, ofp, cr;
  logic [3:0]  oid;
  logic [31:0] od;
  logic pop_ready_o, fpu_in_valid_o, fpu_out_ready_o, fpr_we_o, c_p_valid_o, idle_o;
  logic [3:0]  c_p_id_o;
  logic [31:0] c_p_data_o;
  logic [2:0]  outstanding_o;
  logic [1:0]  resp_usage_o;

  fpu_ss_wb_ctrl #(.MAX_OUTSTANDING(MAXO), .RESP_DEPTH(DEP), .ID_WIDTH(4), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .pop_valid_i(pv), .pop_ready_o(pop_ready_o), .use_fpu_i(uf), .csr_instr_i(csr),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(ir),
    .fpu_out_valid_i(ov), .fpu_out_ready_o(fpu_out_ready_o), .fpu_out_rd_is_fp_i(ofp),
    .fpu_out_id_i(oid), .fpu_out_data_i(od), .fpr_we_o(fpr_we_o),
    .c_p_valid_o(c_p_valid_o), .c_p_ready_i(cr), .c_p_id_o(c_p_id_o), .c_p_data_o(c_p_data_o),
    .outstanding_o(outstanding_o), .resp_usage_o(resp_usage_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0;

  // transaction-level model
  int           m_out;
  logic [35:0]  m_q[$];
  bit           m_drain;

  // sampled DUT values and model expectations for the current cycle
  logic s_pr, s_fiv, s_ordy, s_we, s_cpv, s_idle;
  logic [3:0] s_id;  logic [31:0] s_data;  int s_out, s_use;
  logic e_pr, e_fiv, e_ordy, e_we, e_cpv, e_idle;
  logic [3:0] e_id;  logic [31:0] e_data;  int e_out, e_use;

  task automatic model_reset();
    m_out = 0; m_q.delete(); m_drain = 0;
  endtask

  task automatic drive(input bit p, u, c, r, v, f, input logic [3:0] i, input logic [31:0] d, input bit k);
    pv = p; uf = u; csr = c; ir = r; ov = v; ofp = f; oid = i; od = d; cr = k;
  endtask

  // One clock: sample at negedge, predict from the model, update model after posedge.
  task automatic tick();
    int use_n; bit idl, iss, dq, rh; logic [35:0] hd;
    @(negedge clk_i);
    s_pr = pop_ready_o; s_fiv = fpu_in_valid_o; s_ordy = fpu_out_ready_o; s_we = fpr_we_o;
    s_cpv = c_p_valid_o; s_idle = idle_o; s_id = c_p_id_o; s_data = c_p_data_o;
    s_out = int'(outstanding_o); s_use = int'(resp_usage_o);
    use_n = m_q.size();
    idl   = (m_out == 0) && (use_n == 0);
    e_fiv = pv & uf & !m_drain & (m_out < MAXO);
    iss   = e_fiv & ir;
    e_pr  = iss | (!m_drain & pv & !uf & !csr) | (!m_drain & pv & csr & idl);
    e_cpv = (use_n != 0);
    hd    = e_cpv ? m_q[0] : 36'd0;
    e_id  = hd[35:32]; e_data = hd[31:0];
    dq    = e_cpv & cr;
    e_ordy = ofp | (use_n < DEP) | dq;
    e_we  = ov & ofp;
    e_out = m_out; e_use = use_n; e_idle = idl;
    rh    = ov & e_ordy;
    @(posedge clk_i); #1;
    if (dq) void'(m_q.pop_front());
    if (rh && !ofp) m_q.push_back({oid, od});
    m_out = m_out + int'(iss) - int'(rh);
    if (!m_drain && pv && csr && !idl) m_drain = 1;
    else if (m_drain && idl) m_drain = 0;
  endtask

  task automatic test_reset();
    n_chk++; if (idle_o !== 1'b1) $display("FAIL reset_idle got %b exp 1", idle_o); else n_pass++;
    n_chk++; if (c_p_valid_o !== 1'b0) $display("FAIL reset_cpv got %b exp 0", c_p_valid_o); else n_pass++;
    n_chk++; if (outstanding_o !== 3'd0) $display("FAIL reset_out got %0d exp 0", outstanding_o); else n_pass++;
    n_chk++; if (resp_usage_o !== 2'd0) $display("FAIL reset_use got %0d exp 0", resp_usage_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1,1,0,1,0,0,0,0,0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (s_fiv !== 1'b1 || s_pr !== 1'b1) $display("FAIL b2b_issue%0d got fiv=%b pr=%b exp 1/1", i, s_fiv, s_pr); else n_pass++;
    end
    tick();
    n_chk++; if (s_out !== 4) $display("FAIL b2b_out got %0d exp 4", s_out); else n_pass++;
    n_chk++; if (s_fiv !== 1'b0 || s_pr !== 1'b0) $display("FAIL b2b_5th got fiv=%b pr=%b exp 0/0", s_fiv, s_pr); else n_pass++;
    drive(0,0,0,0,1,1,0,0,0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (s_we !== 1'b1 || s_ordy !== 1'b1 || s_cpv !== 1'b0) $display("FAIL b2b_fpret%0d got we=%b rdy=%b cpv=%b exp 1/1/0", i, s_we, s_ordy, s_cpv); else n_pass++;
    end
    drive(0,0,0,0,0,0,0,0,0); tick();
    n_chk++; if (s_out !== 0 || s_idle !== 1'b1) $display("FAIL b2b_drained got out=%0d idle=%b exp 0/1", s_out, s_idle); else n_pass++;
  endtask

  task automatic test_fp_with_issue();
    drive(1,1,0,1,0,0,0,0,0); tick();
    drive(1,1,0,1,1,1,4'h7,32'h1234,0); tick();
    n_chk++; if (s_we !== 1'b1 || s_fiv !== 1'b1) $display("FAIL fpiss_we got we=%b fiv=%b exp 1/1", s_we, s_fiv); else n_pass++;
    drive(0,0,0,0,0,0,0,0,0); tick();
    n_chk++; if (s_out !== 1 || s_cpv !== 1'b0) $display("FAIL fpiss_out got out=%0d cpv=%b exp 1/0", s_out, s_cpv); else n_pass++;
    drive(0,0,0,0,1,1,0,0,0); tick();
    drive(0,0,0,0,0,0,0,0,0); tick();
    n_chk++; if (s_out !== 0) $display("FAIL fpiss_retire got %0d exp 0", s_out); else n_pass++;
  endtask

  task automatic test_fifo_order();
    logic [31:0] d [1:3];
    for (int i = 1; i <= 3; i++) d[i] = $urandom;
    drive(1,1,0,1,0,0,0,0,0); repeat (3) tick();
    drive(0,0,0,0,1,0,4'd1,d[1],0); tick();
    n_chk++; if (s_ordy !== 1'b1 || s_cpv !== 1'b0) $display("FAIL ord_r1 got rdy=%b cpv=%b exp 1/0", s_ordy, s_cpv); else n_pass++;
    drive(0,0,0,0,1,0,4'd2,d[2],0); tick();
    n_chk++; if (s_ordy !== 1'b1 || s_cpv !== 1'b1 || s_id !== 4'd1) $display("FAIL ord_r2 got rdy=%b cpv=%b id=%0d exp 1/1/1", s_ordy, s_cpv, s_id); else n_pass++;
    drive(0,0,0,0,1,0,4'd3,d[3],0); tick();
    n_chk++; if (s_ordy !== 1'b0 || s_use !== 2) $display("FAIL ord_stall got rdy=%b use=%0d exp 0/2", s_ordy, s_use); else n_pass++;
    tick();
    n_chk++; if (s_ordy !== 1'b0) $display("FAIL ord_stall2 got rdy=%b exp 0", s_ordy); else n_pass++;
    drive(0,0,0,0,1,0,4'd3,d[3],1); tick();
    n_chk++; if (s_ordy !== 1'b1 || s_id !== 4'd1 || s_data !== d[1]) $display("FAIL ord_full_deq got rdy=%b id=%0d data=%h exp 1/1/%h", s_ordy, s_id, s_data, d[1]); else n_pass++;
    drive(0,0,0,0,0,0,0,0,1); tick();
    n_chk++; if (s_use !== 2 || s_id !== 4'd2 || s_data !== d[2]) $display("FAIL ord_id2 got use=%0d id=%0d data=%h exp 2/2/%h", s_use, s_id, s_data, d[2]); else n_pass++;
    tick();
    n_chk++; if (s_use !== 1 || s_id !== 4'd3 || s_data !== d[3]) $display("FAIL ord_id3 got use=%0d id=%0d data=%h exp 1/3/%h", s_use, s_id, s_data, d[3]); else n_pass++;
    drive(0,0,0,0,0,0,0,0,0); tick();
    n_chk++; if (s_use !== 0 || s_cpv !== 1'b0 || s_idle !== 1'b1 || s_out !== 0) $display("FAIL ord_empty got use=%0d cpv=%b idle=%b out=%0d exp 0/0/1/0", s_use, s_cpv, s_idle, s_out); else n_pass++;
  endtask

  task automatic test_csr_drain();
    drive(1,1,0,1,0,0,0,0,0); repeat (2) tick();
    drive(1,0,1,0,0,0,0,0,0); tick();
    n_chk++; if (s_pr !== 1'b0 || s_out !== 2) $display("FAIL csr_busy got pr=%b out=%0d exp 0/2", s_pr, s_out); else n_pass++;
    tick();
    n_chk++; if (s_pr !== 1'b0) $display("FAIL csr_drain got pr=%b exp 0", s_pr); else n_pass++;
    drive(1,0,1,0,1,1,0,0,0); tick();
    n_chk++; if (s_pr !== 1'b0) $display("FAIL csr_res1 got pr=%b exp 0", s_pr); else n_pass++;
    tick();
    n_chk++; if (s_pr !== 1'b0) $display("FAIL csr_res2 got pr=%b exp 0", s_pr); else n_pass++;
    drive(1,0,1,0,0,0,0,0,0); tick();
    n_chk++; if (s_idle !== 1'b1 || s_pr !== 1'b0) $display("FAIL csr_idle_drain got idle=%b pr=%b exp 1/0", s_idle, s_pr); else n_pass++;
    tick();
    n_chk++; if (s_pr !== 1'b1) $display("FAIL csr_pop got pr=%b exp 1", s_pr); else n_pass++;
    drive(0,0,0,0,0,0,0,0,0); tick();
  endtask

  task automatic test_async_reset();
    drive(1,1,0,1,0,0,0,0,0); tick();
    drive(0,0,0,0,1,0,4'd5,32'hcafe,0); tick();
    drive(1,0,1,0,0,0,0,0,0); tick();
    n_chk++; if (s_pr !== 1'b0) $display("FAIL ar_enter_drain got pr=%b exp 0", s_pr); else n_pass++;
    tick();
    n_chk++; if (s_use !== 1 || s_pr !== 1'b0) $display("FAIL ar_pre got use=%0d pr=%b exp 1/0", s_use, s_pr); else n_pass++;
    #2 rst_ni = 1'b0;
    #1;
    n_chk++; if (c_p_valid_o !== 1'b0 || idle_o !== 1'b1 || resp_usage_o !== 2'd0 || outstanding_o !== 3'd0)
      $display("FAIL ar_outputs got cpv=%b idle=%b use=%0d out=%0d exp 0/1/0/0", c_p_valid_o, idle_o, resp_usage_o, outstanding_o); else n_pass++;
    n_chk++; if (pop_ready_o !== 1'b1) $display("FAIL ar_run got pr=%b exp 1", pop_ready_o); else n_pass++;
    model_reset();
    drive(0,0,0,0,0,0,0,0,0);
    #1 rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(2);
      pv  = $urandom_range(1); uf = (k == 0); csr = (k == 1);
      ir  = $urandom_range(1);
      ov  = (m_out > 0) ? 1'($urandom_range(1)) : 1'b0;
      ofp = $urandom_range(1); oid = 4'($urandom); od = $urandom;
      cr  = ($urandom_range(3) != 0);
      tick();
      n_chk++;
      if (s_pr !== e_pr || s_fiv !== e_fiv || s_ordy !== e_ordy || s_we !== e_we || s_cpv !== e_cpv ||
          s_idle !== e_idle || s_out !== e_out || s_use !== e_use || (e_cpv && (s_id !== e_id || s_data !== e_data)))
        $display("FAIL rand%0d got pr%b fiv%b rdy%b we%b cpv%b idle%b out%0d use%0d id%0d d%h exp pr%b fiv%b rdy%b we%b cpv%b idle%b out%0d use%0d id%0d d%h",
                 n, s_pr, s_fiv, s_ordy, s_we, s_cpv, s_idle, s_out, s_use, s_id, s_data,
                 e_pr, e_fiv, e_ordy, e_we, e_cpv, e_idle, e_out, e_use, e_id, e_data);
      else n_pass++;
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0,0,0,0,0,0,0,0,0);
    model_reset();
    #12;
    test_reset();
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    test_back_to_back();
    test_fp_with_issue();
    test_fifo_order();
    test_csr_drain();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
